// File: rtl/sfifo_pkg.sv
// rtl/sfifo_pkg.sv - shared constants and types for the FIFO read-side streamer
package sfifo_pkg;

    localparam int FIFO_RD_LAT  = 1;
    localparam int RD_BUF_DEPTH = 2;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/sfifo_rd_stream_if.sv
// rtl/sfifo_rd_stream_if.sv - FIFO read port plus valid/ready stream bundle
interface sfifo_rd_stream_if #(
    parameter int WIDTH = 8
);
    logic             fifo_rempty;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_rinc;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (
        input  fifo_rempty, fifo_rdata, m_ready,
        output fifo_rinc, m_valid, m_data
    );

    modport slave (
        output fifo_rempty, fifo_rdata, m_ready,
        input  fifo_rinc, m_valid, m_data
    );
endinterface

// File: rtl/sfifo_rd_skid.sv
// rtl/sfifo_rd_skid.sv - 2-entry prefetch buffer; pop shifts slot1 to head, capture fills first free slot
module sfifo_rd_skid
    import sfifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pop,
    input  logic             i_cap,
    input  logic [WIDTH-1:0] i_din,
    output occ_t             o_cnt,
    output logic [WIDTH-1:0] o_head
);

    occ_t             r_cnt;
    occ_t             w_cnt_pop;
    occ_t             w_cnt_nxt;
    logic [WIDTH-1:0] r_slot0;
    logic [WIDTH-1:0] r_slot1;
    logic [WIDTH-1:0] w_slot0_nxt;
    logic [WIDTH-1:0] w_slot1_nxt;

    // Shift first, then place the incoming word behind whatever survived the pop.
    always_comb begin
        w_slot0_nxt = r_slot0;
        w_slot1_nxt = r_slot1;
        w_cnt_pop   = r_cnt;
        if (i_pop) begin
            w_slot0_nxt = r_slot1;
            w_cnt_pop   = r_cnt - occ_t'(1);
        end
        w_cnt_nxt = w_cnt_pop;
        if (i_cap) begin
            if (w_cnt_pop == occ_t'(0)) begin
                w_slot0_nxt = i_din;
            end else begin
                w_slot1_nxt = i_din;
            end
            w_cnt_nxt = w_cnt_pop + occ_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_slot0 <= w_slot0_nxt;
            r_slot1 <= w_slot1_nxt;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_head = r_slot0;

endmodule

// File: rtl/sfifo_rd_stream.sv
// rtl/sfifo_rd_stream.sv - drains the sync FIFO read port into a valid/ready stream
// Optional delivered-word counter on rd_count when RD_STATS_EN is defined.
module sfifo_rd_stream
    import sfifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sfifo_rd_stream_if.master    bus
`ifdef RD_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] rd_count
`endif
);

    logic                   w_pop;
    logic                   w_cap;
    occ_t                   w_cnt;
    logic [WIDTH-1:0]       w_head;
    logic [2:0]             w_credit;
    logic [FIFO_RD_LAT-1:0] r_inflight;

    assign w_cap       = r_inflight[FIFO_RD_LAT-1];
    assign bus.m_valid = (w_cnt != occ_t'(0));
    assign bus.m_data  = w_head;
    assign w_pop       = bus.m_valid & bus.m_ready;

    // Words held plus words still in the FIFO pipe, after this cycle's pop leaves.
    assign w_credit      = 3'(w_cnt) + 3'($countones(r_inflight)) - 3'(w_pop);
    assign bus.fifo_rinc = rst_n & ~bus.fifo_rempty & (w_credit < 3'(RD_BUF_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= FIFO_RD_LAT'({r_inflight, bus.fifo_rinc});
        end
    end

    sfifo_rd_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_pop  (w_pop),
        .i_cap  (w_cap),
        .i_din  (bus.fifo_rdata),
        .o_cnt  (w_cnt),
        .o_head (w_head)
    );

`ifdef RD_STATS_EN
    logic [CNT_WIDTH-1:0] r_rd_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= '0;
        end else if (w_pop) begin
            r_rd_count <= r_rd_count + CNT_WIDTH'(1);
        end
    end

    assign rd_count = r_rd_count;
`endif

endmodule

// File: tb/tb_sfifo_rd_stream.sv
// tb/tb_sfifo_rd_stream.sv - scoreboard bench for sfifo_rd_stream with a behavioural FIFO
module tb_sfifo_rd_stream;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sfifo_rd_stream_if #(.WIDTH(W)) bus ();

`ifdef RD_STATS_EN
    logic [7:0] rd_count;
    sfifo_rd_stream #(.WIDTH(W), .CNT_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .rd_count (rd_count)
    );
`else
    sfifo_rd_stream #(.WIDTH(W), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    int total = 0;
    int bad = 0;
    int rinc_total = 0;
    int outstanding = 0;
    logic [W-1:0] fq[$];
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural FIFO (one-cycle read latency) plus stream monitor, all sampled at posedge.
    always @(posedge clk) begin
        logic [W-1:0] w;
        logic pop;
        pop = rst_n && bus.m_valid && bus.m_ready;
        if (bus.fifo_rinc) begin
            chk("rinc_while_empty", {31'b0, bus.fifo_rempty}, 0);
            rinc_total++;
            if (fq.size() > 0) begin
                w = fq.pop_front();
                bus.fifo_rdata <= w;
            end
        end
        bus.fifo_rempty <= (fq.size() == 0);
        if (!rst_n) begin
            outstanding = 0;
        end else begin
            outstanding = outstanding + int'(bus.fifo_rinc) - int'(pop);
            if (bus.fifo_rinc) chk("credit_bound", (outstanding <= 2), 1);
        end
        if (pop) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_word: got 0x%0h want no word at %0t", bus.m_data, $time);
            end else begin
                w = exp_q.pop_front();
                chk("order", {24'b0, bus.m_data}, {24'b0, w});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [W-1:0] d);
        fq.push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic drain(input int bound);
        int c = 0;
        while (exp_q.size() != 0 && c < bound) begin
            cyc(1);
            c++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] rinc_tab;
        logic [5:0] valid_tab;
        logic [W-1:0] t1 [3];
        logic [W-1:0] bp [5];
        int base;
        int vcnt;
        int pushed;
        int cycles;

        bus.m_ready = 1'b0;
        cyc(2);

        // Reset state and preload; rempty low takes effect at next edge.
        chk("reset_m_valid", {31'b0, bus.m_valid}, 0);
        chk("reset_rinc", {31'b0, bus.fifo_rinc}, 0);
        chk("reset_m_data", {24'b0, bus.m_data}, 0);
        t1 = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) push(t1[i]);
        bus.m_ready = 1'b1;
        cyc(1);
        chk("reset_hold_rinc", {31'b0, bus.fifo_rinc}, 0);
        rst_n = 1'b1;
        rinc_tab  = 6'b000111;
        valid_tab = 6'b011100;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t1_rinc", {31'b0, bus.fifo_rinc}, {31'b0, rinc_tab[i]});
            chk("t1_valid", {31'b0, bus.m_valid}, {31'b0, valid_tab[i]});
            if (i >= 2 && i <= 4) chk("t1_data", {24'b0, bus.m_data}, {24'b0, t1[i-2]});
            @(posedge clk);
            #1;
        end
        chk("t1_drained", exp_q.size(), 0);

        // Backpressure: only two words may be pulled while m_ready is low.
        bus.m_ready = 1'b0;
        base = rinc_total;
        bp = '{8'h3C, 8'h5A, 8'h96, 8'hC3, 8'hE7};
        for (int i = 0; i < 5; i++) push(bp[i]);
        cyc(8);
        chk("bp_rinc_count", rinc_total - base, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", {31'b0, bus.m_valid}, 1);
            chk("bp_data_hold", {24'b0, bus.m_data}, 32'h3C);
            chk("bp_rinc_low", {31'b0, bus.fifo_rinc}, 0);
            @(posedge clk);
            #1;
        end
        bus.m_ready = 1'b1;
        drain(40);
        chk("bp_fifo_empty", fq.size(), 0);

        // Single word then idle.
        cyc(3);
        base = rinc_total;
        vcnt = 0;
        push(8'hA5);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.m_valid) vcnt++;
            @(posedge clk);
            #1;
        end
        chk("empty_rinc_count", rinc_total - base, 1);
        chk("empty_valid_cycles", vcnt, 1);
        @(negedge clk);
        chk("empty_rinc_idle", {31'b0, bus.fifo_rinc}, 0);
        chk("empty_valid_idle", {31'b0, bus.m_valid}, 0);
        @(posedge clk);
        #1;

        // Random backpressure and FIFO fill.
        pushed = 0;
        cycles = 0;
        while ((pushed < 1000 || exp_q.size() != 0) && cycles < 20000) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            if (pushed < 1000 && fq.size() < 8 && $urandom_range(0, 1) == 1) begin
                push(W'($urandom_range(0, 255)));
                pushed++;
            end
            cyc(1);
            cycles++;
        end
        chk("rand_timeout", (cycles < 20000), 1);
        chk("rand_left", exp_q.size(), 0);

        // Reset with one word buffered and one in flight.
        bus.m_ready = 1'b0;
        cyc(2);
        base = rinc_total;
        push(8'hC1);
        push(8'hC2);
        push(8'hC3);
        push(8'hC4);
        cyc(3);
        chk("mid_pre_valid", {31'b0, bus.m_valid}, 1);
        chk("mid_pre_data", {24'b0, bus.m_data}, 32'hC1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid_now", {31'b0, bus.m_valid}, 0);
        chk("mid_rinc_now", {31'b0, bus.fifo_rinc}, 0);
        chk("mid_data_now", {24'b0, bus.m_data}, 0);
        cyc(2);
        chk("mid_rinc_count", rinc_total - base, 2);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_post_valid", {31'b0, bus.m_valid}, 0);
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        drain(40);

`ifdef RD_STATS_EN
        rst_n = 1'b0;
        cyc(1);
        chk("stats_reset", {24'b0, rd_count}, 0);
        rst_n = 1'b1;
        pushed = 0;
        cycles = 0;
        while (pushed < 300 && cycles < 2000) begin
            if (fq.size() < 4) begin
                push(W'(pushed));
                pushed++;
            end
            cyc(1);
            cycles++;
        end
        drain(40);
        cyc(2);
        chk("stats_wrap", {24'b0, rd_count}, 44);
        rst_n = 1'b0;
        #1;
        chk("stats_reset_again", {24'b0, rd_count}, 0);
        cyc(1);
        rst_n = 1'b1;
`endif

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
